// File: rtl/axi_brs.sv
// -----------------------------------------------------------------------------
// axi_brs -- full AXI-style register slice (main register + skid register).
//
// Breaks every combinational path between the upstream and downstream
// handshakes. All outputs come straight from flops, so the slice can sit
// between two timing-critical blocks without adding logic on either side.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   m_data   in   [DW]  upstream payload
//   m_valid  in   upstream valid
//   m_ready  out  upstream ready (flop)
//   s_data   out  [DW]  downstream payload (main register)
//   s_valid  out  downstream valid (flop)
//   s_ready  in   downstream ready
//   count    out  [2]   occupancy: 0, 1 or 2 beats held
// -----------------------------------------------------------------------------
module axi_brs #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] m_data,
    input  logic          m_valid,
    output logic          m_ready,
    output logic [DW-1:0] s_data,
    output logic          s_valid,
    input  logic          s_ready,
    output logic [1:0]    count
);

    // State encoding equals the occupancy, so count is the state flop itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [DW-1:0] skid;
    logic          accept;
    logic          take;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;
    logic          s_valid_d;
    logic          m_ready_d;

    assign accept = m_valid & m_ready;
    assign take   = s_valid & s_ready;
    assign count  = state;

    // State register. s_valid and m_ready are registered copies of the state
    // decode (computed from the next state) so they leave the block from flops.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            s_valid <= 1'b0;
            m_ready <= 1'b1;
        end else begin
            state   <= state_d;
            s_valid <= s_valid_d;
            m_ready <= m_ready_d;
        end
    end

    // Next-state and datapath load enables.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without that, synthesis infers a latch.
    always_comb begin
        state_d        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (accept && take) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // m_ready is low here, so no upstream beat can arrive.
                if (take) begin
                    load_main_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output decode of the next state; registered above.
    always_comb begin
        s_valid_d = (state_d != EMPTY);
        m_ready_d = (state_d != FULL);
    end

    // Payload registers. Only the main register feeds s_data; the skid
    // register absorbs the one beat accepted in the cycle s_ready drops.
    // NOTE: the payload registers are reset too, so s_data reads zero after
    // reset and no stale beat survives a mid-operation reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data <= '0;
            skid   <= '0;
        end else begin
            if (load_main_in) begin
                s_data <= m_data;
            end else if (load_main_skid) begin
                s_data <= skid;
            end
            if (load_skid) begin
                skid <= m_data;
            end
        end
    end

endmodule

// File: tb/tb_axi_brs.sv
// -----------------------------------------------------------------------------
// tb_axi_brs -- self-checking bench for axi_brs.
//
// A queue holds the beats the slice should currently contain. Each cycle the
// DUT outputs are compared against it at the falling edge (occupancy, valid,
// ready, head payload); the queue is then updated from the stimulus using the
// transfer rules, independently of the DUT's own handshake outputs.
// -----------------------------------------------------------------------------
module tb_axi_brs;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    count;

    logic [DW-1:0] q[$];
    int            checks    = 0;
    int            failures  = 0;
    int            accepted  = 0;
    int            delivered = 0;
    string         phase     = "init";

    axi_brs #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, observed, expected);
        end
    endtask

    // Compare DUT outputs against the model's current contents.
    task automatic check_state(input string tag);
        check({tag, "_count"},   DW'(count),   DW'(q.size()));
        check({tag, "_s_valid"}, DW'(s_valid), DW'(q.size() != 0));
        check({tag, "_m_ready"}, DW'(m_ready), DW'(q.size() != 2));
        if (q.size() != 0) begin
            check({tag, "_s_data"}, s_data, q[0]);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, confirm the outputs did
    // not react combinationally, then advance the model across the next edge.
    task automatic step(input logic mv, input logic [DW-1:0] md, input logic sr);
        logic acc;
        logic tk;
        @(negedge clk);
        check_state("pre");
        m_valid = mv;
        m_data  = md;
        s_ready = sr;
        #1;
        check("m_ready_stable", DW'(m_ready), DW'(q.size() != 2));
        check("s_valid_stable", DW'(s_valid), DW'(q.size() != 0));
        acc = mv && (q.size() < 2);
        tk  = sr && (q.size() > 0);
        if (tk) begin
            void'(q.pop_front());
            delivered++;
        end
        if (acc) begin
            q.push_back(md);
            accepted++;
        end
    endtask

    initial begin
        int base;
        int cyc;

        // Reset: held low for three cycles, then released.
        phase   = "reset";
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("s_valid", DW'(s_valid), DW'(1'b0));
        check("m_ready", DW'(m_ready), DW'(1'b1));
        check("count",   DW'(count),   DW'(2'd0));
        check("s_data",  s_data,       DW'(0));

        // Streaming: eight back-to-back beats with the sink always ready.
        phase = "stream";
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b1);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Back-pressure: 0xA in main, then 0xB arrives while the sink stalls.
        phase = "backpressure";
        step(1'b1, DW'('hA), 1'b1);
        step(1'b1, DW'('hB), 1'b0);
        // FULL now: 0xC must be ignored while m_ready is low.
        step(1'b1, DW'('hC), 1'b0);
        step(1'b1, DW'('hD), 1'b0);
        check("full_count",   DW'(count),   DW'(2'd2));
        check("full_m_ready", DW'(m_ready), DW'(1'b0));
        check("full_s_data",  s_data,       DW'('hA));

        // Release: two ready cycles deliver 0xA then 0xB and drain the slice.
        phase = "release";
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("drained_count",   DW'(count),   DW'(2'd0));
        check("drained_m_ready", DW'(m_ready), DW'(1'b1));

        // Random stress until 10000 beats have been accepted.
        phase = "stress";
        base  = accepted;
        cyc   = 0;
        while ((accepted - base) < 10000 && cyc < 60000) begin
            step($urandom_range(0, 3) != 0, DW'({$urandom(), $urandom()}),
                 $urandom_range(0, 3) != 0);
            cyc++;
        end
        check("beats_accepted", DW'(accepted - base >= 10000), DW'(1'b1));
        cyc = 0;
        while (q.size() != 0 && cyc < 8) begin
            step(1'b0, '0, 1'b1);
            cyc++;
        end
        step(1'b0, '0, 1'b0);
        check("all_delivered", DW'(delivered), DW'(accepted));

        // Mid-operation reset from FULL.
        phase = "midreset";
        step(1'b1, DW'('hA), 1'b1);
        step(1'b1, DW'('hB), 1'b0);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("s_valid", DW'(s_valid), DW'(1'b0));
        check("m_ready", DW'(m_ready), DW'(1'b1));
        check("count",   DW'(count),   DW'(2'd0));
        check("s_data",  s_data,       DW'(0));
        q.delete();
        m_valid = 1'b0;
        s_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Nothing stale may appear, and the first beat is taken immediately.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, DW'('h55), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("after_count", DW'(count), DW'(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_brs.md
AXI_BRS -- requirements
Module: axi_brs

Interface
REQ-001 The block SHALL have parameter DW, default 64, giving the payload width in bits.
REQ-002 Port clk SHALL be an input, 1 bit wide, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, the reset: asynchronous, active-low.
REQ-004 Port m_data SHALL be an input, DW bits wide, the upstream payload.
REQ-005 Port m_valid SHALL be an input, 1 bit wide, the upstream valid.
REQ-006 Port m_ready SHALL be an output, 1 bit wide, the upstream ready, driven directly from a flop.
REQ-007 Port s_data SHALL be an output, DW bits wide, the downstream payload, driven directly from a flop.
REQ-008 Port s_valid SHALL be an output, 1 bit wide, the downstream valid, driven directly from a flop.
REQ-009 Port s_ready SHALL be an input, 1 bit wide, the downstream ready.
REQ-010 Port count SHALL be an output, 2 bits wide, giving the current occupancy (0, 1 or 2).

Function
REQ-011 The block SHALL be a full register slice: a main register (drives s_data) plus a skid register, with no combinational path from any input to any output.
REQ-012 Transfer rules SHALL be: upstream beat accepted when m_valid & m_ready; downstream beat taken when s_valid & s_ready.
REQ-013 The FSM SHALL have three states: EMPTY (count=0), BUSY (count=1, beat in main), FULL (count=2, beats in main and skid).
REQ-014 Outputs SHALL decode from the state: s_valid = (state != EMPTY); m_ready = (state != FULL).
REQ-015 EMPTY transitions SHALL be:
- m_valid=1: main <= m_data, go to BUSY.
- otherwise: stay in EMPTY.
REQ-016 BUSY transitions SHALL be:
- accept and take together: main <= m_data, stay in BUSY.
- accept only: skid <= m_data, go to FULL.
- take only: go to EMPTY.
- neither: hold.
REQ-017 FULL transitions SHALL be:
- s_ready=1: main <= skid, go to BUSY.
- otherwise: hold; no upstream beat is accepted in FULL.
REQ-018 Latency SHALL be 1 cycle from upstream acceptance to s_valid=1 when the slice is EMPTY.
REQ-019 Sustained throughput SHALL be 1 beat per cycle while s_ready=1.
REQ-020 Ordering SHALL be strict FIFO; no beat is dropped or duplicated.
REQ-021 Held data SHALL be stable: s_data is unchanged while s_valid=1 & s_ready=0.
REQ-022 The skid register SHALL be written only on the BUSY "accept only" transition.
REQ-023 Upstream stability SHALL be tolerated: m_data and m_valid changing while m_ready=0 SHALL have no effect.
REQ-024 An s_ready deassertion SHALL be absorbed with no upstream beat lost: m_ready drops one cycle later, and the skid register holds the beat accepted in that cycle.

Reset
REQ-025 Asserting rst_n=0 SHALL, asynchronously and regardless of state, force:
- state = EMPTY
- s_valid = 0
- m_ready = 1
- count = 0
- s_data = 0
- skid = 0
REQ-026 Reset asserted mid-operation SHALL discard all held beats.
REQ-027 After reset release, the first upstream beat SHALL be accepted on the first clock edge with m_valid=1.

Verification
REQ-028 Reset check: rst_n=0 for 3 cycles, then release -> s_valid=0, m_ready=1, count=0, s_data=0.
REQ-029 Streaming: s_ready=1, beats 0x1..0x8 back-to-back -> s_data=0x1..0x8 on consecutive cycles, first one 1 cycle after acceptance, count stays 1, m_ready stays 1.
REQ-030 Back-pressure: BUSY with 0xA in main, s_ready=0 while 0xB is presented -> 0xB accepted, state FULL, count=2, m_ready=0 next cycle, s_data holds 0xA.
REQ-031 Release: from FULL (0xA, 0xB), assert s_ready for 2 cycles -> 0xA then 0xB delivered, count goes 2->1->0, m_ready=1 again.
REQ-032 Random stress: random m_valid/s_ready over 10k beats -> scoreboard shows in-order, lossless delivery; m_ready and s_valid never glitch within a cycle.
REQ-033 Mid-operation reset: assert rst_n=0 asynchronously in FULL -> outputs reach reset values before the next clock edge; stale 0xA/0xB are never delivered afterwards.
